// File: rtl/alu_pkg.sv
// Shared constants and types for the registered ALU decoder with M-extension sequencing.
// Holds ALU control codes, ALU_Op and funct7 encodings, the FSM state enum and
// the packed decode record passed from the combinational decoder to the top.
package alu_pkg;

  // ALU control codes (4-bit core, zero-extended at the top when CTRL_W > 4)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // ALU_Op encodings from the main decoder
  localparam logic [1:0] ALUOP_MEM = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALUOP_RI  = 2'b10;  // R-type / I-type arithmetic
  localparam logic [1:0] ALUOP_RSV = 2'b11;  // reserved

  // funct7 encodings
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One decoded instruction: ALU code, mul/div select and op, illegal flag
  typedef struct packed {
    logic [3:0] code;
    logic       md_sel;
    logic [2:0] md_op;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_comb.sv
// Purely combinational ALU/M-extension decode of ALU_Op, OP5, funct7, funct3.
// Latency: 0 cycles (combinational). Backpressure: none, pure function of inputs.
// Ports: ALU_Op/OP5/funct7/funct3 in; dec (code, md_sel, md_op, illegal) out.
module alu_ctrl_comb
  import alu_pkg::*;
#(
  parameter int MD_EN = 1
) (
  input  logic [1:0] ALU_Op,
  input  logic       OP5,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output dec_t       dec
);

  localparam bit MdOn = (MD_EN != 0);

  logic is_md;
  logic rtype_ok;
  logic itype_bad;

  always_comb begin
    dec       = '0;
    is_md     = MdOn & OP5 & (funct7 == F7_MD);
    // R-type: only the base encoding, the SUB/SRA alternate, or M ops when enabled
    rtype_ok  = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                is_md;
    // I-type: funct7 is immediate except for shifts, where it carries the shift kind
    itype_bad = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));

    unique case (ALU_Op)
      ALUOP_MEM: dec.code = ALU_ADD;
      ALUOP_BR:  dec.code = ALU_SUB;
      ALUOP_RSV: begin
        dec.code    = ALU_ADD;
        dec.illegal = 1'b1;
      end
      default: begin
        // funct7-based legality only means something for arithmetic ops
        dec.illegal = OP5 ? ~rtype_ok : itype_bad;
        if (is_md) begin
          dec.code   = ALU_ADD;
          dec.md_sel = 1'b1;
          dec.md_op  = funct3;
        end else begin
          case (funct3)
            3'b000: dec.code = (OP5 && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            3'b001: dec.code = ALU_SLL;
            3'b010: dec.code = ALU_SLT;
            3'b011: dec.code = ALU_SLTU;
            3'b100: dec.code = ALU_XOR;
            3'b101: dec.code = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: dec.code = ALU_OR;
            default: dec.code = ALU_AND;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_decoder_md_seq.sv
// Registered ALU decoder with M-extension sequencing and a one-entry valid/ready output stage.
// Latency: 1 cycle for ALU ops; M ops add MUL_LAT/DIV_LAT BUSY cycles after the md_start pulse.
// Backpressure: in_ready low while BUSY; in DONE in_ready follows out_ready so a release can accept back-to-back.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + ALU_Op/OP5/funct7/funct3 request;
//        out_valid/out_ready + alu_ctrl/md_sel/md_op/illegal result; md_start pulse; busy status.
module alu_decoder_md_seq
  import alu_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MD_EN   = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALU_Op,
  input  logic              OP5,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              md_sel,
  output logic [2:0]        md_op,
  output logic              md_start,
  output logic              illegal,
  output logic              busy
);

  // Counter load values: BUSY lasts exactly LAT cycles, exiting when cnt reaches 0
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  dec_t             dec_new;
  dec_t             dec_q;
  logic             md_start_q;
  logic             accept;

  alu_ctrl_comb #(
    .MD_EN (MD_EN)
  ) u_ctrl_comb (
    .ALU_Op (ALU_Op),
    .OP5    (OP5),
    .funct7 (funct7),
    .funct3 (funct3),
    .dec    (dec_new)
  );

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = dec_new.md_sel ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // A new accept replaces the released result with no bubble
        if (accept)         state_nxt = dec_new.md_sel ? ST_BUSY : ST_DONE;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Result register, latency counter and md_start pulse.
  // md_start_q is only set on the edge that accepts an M op, so it is high in the
  // first BUSY cycle and never in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q      <= '0;
      cnt        <= '0;
      md_start_q <= 1'b0;
    end else begin
      md_start_q <= accept & dec_new.md_sel;
      if (accept) begin
        dec_q <= dec_new;
        if (dec_new.md_sel) cnt <= dec_new.md_op[2] ? DIV_LAST : MUL_LAST;
        else                cnt <= '0;
      end else if ((state == ST_BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign alu_ctrl = CTRL_W'(dec_q.code);
  assign md_sel   = dec_q.md_sel;
  assign md_op    = dec_q.md_op;
  assign illegal  = dec_q.illegal;
  assign md_start = md_start_q;

endmodule

// File: tb/tb_alu_decoder_md_seq.sv
// Self-checking bench: transaction-level reference model with per-cycle compare for two builds
// (MD_EN=1 and MD_EN=0), directed scenarios with literal expectations, then randomized traffic.
module tb_alu_decoder_md_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] ALU_Op;
  logic       OP5;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       out_ready;

  logic [1:0]      in_ready_w;
  logic [1:0]      out_valid_w;
  logic [1:0]      md_sel_w;
  logic [1:0]      md_start_w;
  logic [1:0]      illegal_w;
  logic [1:0]      busy_w;
  logic [1:0][3:0] alu_ctrl_w;
  logic [1:0][2:0] md_op_w;

  int n_chk  = 0;
  int n_fail = 0;

  alu_decoder_md_seq #(
    .CTRL_W(4), .MD_EN(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .ALU_Op(ALU_Op), .OP5(OP5), .funct7(funct7), .funct3(funct3),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .alu_ctrl(alu_ctrl_w[0]),
    .md_sel(md_sel_w[0]), .md_op(md_op_w[0]), .md_start(md_start_w[0]),
    .illegal(illegal_w[0]), .busy(busy_w[0])
  );

  alu_decoder_md_seq #(
    .CTRL_W(4), .MD_EN(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)
  ) u_dut_nomd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .ALU_Op(ALU_Op), .OP5(OP5), .funct7(funct7), .funct3(funct3),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .alu_ctrl(alu_ctrl_w[1]),
    .md_sel(md_sel_w[1]), .md_op(md_op_w[1]), .md_start(md_start_w[1]),
    .illegal(illegal_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] ctrl;
    logic       md;
    logic [2:0] op;
    logic       ill;
  } exp_t;

  function automatic exp_t ref_decode(input logic [1:0] aop, input logic op5,
                                      input logic [6:0] f7, input logic [2:0] f3,
                                      input bit md_en);
    exp_t r;
    int   base_code [8];
    bit   legal;
    base_code = '{0, 7, 5, 6, 4, 8, 3, 2};  // ADD SLL SLT SLTU XOR SRL OR AND by funct3
    r = '0;
    if (aop == 2'd3) begin
      r.ill = 1'b1;
    end else if (aop == 2'd1) begin
      r.ctrl = 4'd1;
    end else if (aop == 2'd2) begin
      if (md_en && op5 && f7 == 7'd1) begin
        r.md = 1'b1;
        r.op = f3;
      end else begin
        r.ctrl = 4'(base_code[f3]);
        if (f3 == 3'd0 && op5 && f7 == 7'h20) r.ctrl = 4'd1;
        if (f3 == 3'd5 && f7[5])              r.ctrl = 4'd9;
      end
      if (op5) begin
        legal = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                (f7 == 7'd1 && md_en);
        r.ill = !legal;
      end else begin
        r.ill = (f3 == 3'd1 && f7 != 7'd0) ||
                (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'h20);
      end
    end
    return r;
  endfunction

  // One outstanding transaction per build: its decode, when it becomes visible
  // and when its md_start pulse is due (counted in clock edges).
  bit   pv     [2];
  exp_t pd     [2];
  int   pready [2];
  int   pstart [2];
  bit   started  = 1'b0;
  bit   just_rst = 1'b0;
  int   now      = 0;

  always @(negedge clk) begin
    bit   ev, eb, es, er, acc, rel;
    exp_t d;
    int   lat;
    for (int i = 0; i < 2; i++) begin
      ev = pv[i] && (now >= pready[i]);
      eb = pv[i] && pd[i].md && (now < pready[i]);
      es = pv[i] && pd[i].md && (now == pstart[i]);
      er = !pv[i] ? 1'b1 : ((now < pready[i]) ? 1'b0 : out_ready);
      if (started) begin
        chk($sformatf("out_valid%0d", i), 32'(out_valid_w[i]), 32'(ev));
        chk($sformatf("busy%0d", i),      32'(busy_w[i]),      32'(eb));
        chk($sformatf("md_start%0d", i),  32'(md_start_w[i]),  32'(es));
        chk($sformatf("in_ready%0d", i),  32'(in_ready_w[i]),  32'(er));
        if (ev) begin
          chk($sformatf("alu_ctrl%0d", i), 32'(alu_ctrl_w[i]), 32'(pd[i].ctrl));
          chk($sformatf("md_sel%0d", i),   32'(md_sel_w[i]),   32'(pd[i].md));
          chk($sformatf("illegal%0d", i),  32'(illegal_w[i]),  32'(pd[i].ill));
          if (pd[i].md) chk($sformatf("md_op%0d", i), 32'(md_op_w[i]), 32'(pd[i].op));
        end
        if (just_rst) begin
          chk($sformatf("rst_alu_ctrl%0d", i), 32'(alu_ctrl_w[i]), 32'd0);
          chk($sformatf("rst_md_sel%0d", i),   32'(md_sel_w[i]),   32'd0);
          chk($sformatf("rst_md_op%0d", i),    32'(md_op_w[i]),    32'd0);
          chk($sformatf("rst_illegal%0d", i),  32'(illegal_w[i]),  32'd0);
        end
      end
      // advance the model across the coming edge
      if (!rst_n) begin
        pv[i] = 1'b0;
      end else if (started) begin
        acc = in_valid && er;
        rel = ev && out_ready;
        if (rel) pv[i] = 1'b0;
        if (acc) begin
          d = ref_decode(ALU_Op, OP5, funct7, funct3, (i == 0));
          lat = d.md ? (funct3[2] ? DIV_LAT : MUL_LAT) : 0;
          pv[i]     = 1'b1;
          pd[i]     = d;
          pstart[i] = now + 1;
          pready[i] = now + 1 + lat;
        end
      end
    end
    if (!rst_n) begin
      just_rst = 1'b1;
      started  = 1'b1;
    end else begin
      just_rst = 1'b0;
    end
    now++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [1:0] a, input logic o, input logic [6:0] f7,
                        input logic [2:0] f3);
    ALU_Op = a; OP5 = o; funct7 = f7; funct3 = f3;
  endtask

  typedef struct packed {
    logic [1:0] a;
    logic       o;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t tbl [10];

  initial begin
    exp_t r;
    int   cyc;
    int   sel;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'b00, 1'b0, 7'd0, 3'd0);

    // Pin the model against hand-derived values
    r = ref_decode(2'b10, 1'b1, 7'b0100000, 3'b000, 1'b1);
    chk("model_sub", 32'({r.ctrl, r.ill}), 32'({4'd1, 1'b0}));
    r = ref_decode(2'b10, 1'b1, 7'b0000001, 3'b110, 1'b1);
    chk("model_rem", 32'({r.md, r.op, r.ctrl}), 32'({1'b1, 3'd6, 4'd0}));
    r = ref_decode(2'b10, 1'b1, 7'b0000001, 3'b000, 1'b0);
    chk("model_nomd", 32'({r.md, r.ill, r.ctrl}), 32'({1'b0, 1'b1, 4'd0}));
    r = ref_decode(2'b10, 1'b0, 7'b1000000, 3'b001, 1'b1);
    chk("model_slli_bad", 32'({r.ill, r.ctrl}), 32'({1'b1, 4'd7}));

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Decode sweep, one op at a time, consumer always ready
    tbl[0] = '{2'b10, 1'b1, 7'b0100000, 3'b000, 4'd1, 1'b0};
    tbl[1] = '{2'b10, 1'b1, 7'b0100000, 3'b101, 4'd9, 1'b0};
    tbl[2] = '{2'b10, 1'b1, 7'b0000000, 3'b111, 4'd2, 1'b0};
    tbl[3] = '{2'b10, 1'b0, 7'b0100000, 3'b101, 4'd9, 1'b0};
    tbl[4] = '{2'b10, 1'b0, 7'b0000000, 3'b101, 4'd8, 1'b0};
    tbl[5] = '{2'b10, 1'b0, 7'b0100000, 3'b000, 4'd0, 1'b0};
    tbl[6] = '{2'b11, 1'b1, 7'b0000000, 3'b100, 4'd0, 1'b1};
    tbl[7] = '{2'b10, 1'b1, 7'b1111111, 3'b000, 4'd0, 1'b1};
    tbl[8] = '{2'b00, 1'b0, 7'b1010101, 3'b010, 4'd0, 1'b0};
    tbl[9] = '{2'b01, 1'b1, 7'b0000000, 3'b001, 4'd1, 1'b0};
    for (int k = 0; k < 10; k++) begin
      set_op(tbl[k].a, tbl[k].o, tbl[k].f7, tbl[k].f3);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("sweep%0d_valid", k), 32'(out_valid_w[0]), 32'd1);
      chk($sformatf("sweep%0d_ctrl", k),  32'(alu_ctrl_w[0]),  32'(tbl[k].ctrl));
      chk($sformatf("sweep%0d_ill", k),   32'(illegal_w[0]),   32'(tbl[k].ill));
      step();
    end

    // MUL: md_start pulse, two BUSY cycles; the MD_EN=0 build flags it illegal in one cycle
    set_op(2'b10, 1'b1, 7'b0000001, 3'b000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mul_start",      32'(md_start_w[0]),  32'd1);
    chk("mul_busy1",      32'(busy_w[0]),      32'd1);
    chk("mul_inrdy",      32'(in_ready_w[0]),  32'd0);
    chk("nomd_valid",     32'(out_valid_w[1]), 32'd1);
    chk("nomd_illegal",   32'(illegal_w[1]),   32'd1);
    chk("nomd_md_sel",    32'(md_sel_w[1]),    32'd0);
    step();
    chk("mul_start_once", 32'(md_start_w[0]),  32'd0);
    chk("mul_busy2",      32'(busy_w[0]),      32'd1);
    step();
    chk("mul_valid",      32'(out_valid_w[0]), 32'd1);
    chk("mul_md_sel",     32'(md_sel_w[0]),    32'd1);
    chk("mul_md_op",      32'(md_op_w[0]),     32'd0);
    chk("mul_busy_end",   32'(busy_w[0]),      32'd0);
    step();

    // DIVU: out_valid 32 cycles after md_start
    set_op(2'b10, 1'b1, 7'b0000001, 3'b101);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("divu_start", 32'(md_start_w[0]), 32'd1);
    cyc = 0;
    while (!out_valid_w[0] && cyc < 100) begin
      step();
      cyc++;
    end
    chk("divu_latency", 32'(cyc), 32'(DIV_LAT));
    chk("divu_md_op", 32'(md_op_w[0]), 32'd5);
    step();

    // Backpressure: result held for 5 cycles, then release + accept with no bubble
    out_ready = 1'b0;
    set_op(2'b10, 1'b1, 7'b0000000, 3'b100);
    in_valid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      set_op(2'($urandom), 1'($urandom), 7'($urandom), 3'($urandom));
      chk("bp_valid", 32'(out_valid_w[0]), 32'd1);
      chk("bp_ctrl",  32'(alu_ctrl_w[0]),  32'd4);
      chk("bp_inrdy", 32'(in_ready_w[0]),  32'd0);
      step();
    end
    out_ready = 1'b1;
    set_op(2'b10, 1'b1, 7'b0000000, 3'b110);
    #1;
    chk("b2b_inrdy", 32'(in_ready_w[0]), 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid_w[0]), 32'd1);
    chk("b2b_ctrl",  32'(alu_ctrl_w[0]),  32'd3);
    step();

    // Reset in the middle of a DIV, with cnt at 10
    set_op(2'b10, 1'b1, 7'b0000001, 3'b100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (21) step();
    rst_n = 1'b0;
    step();
    chk("midrst_busy",  32'(busy_w[0]),      32'd0);
    chk("midrst_valid", 32'(out_valid_w[0]), 32'd0);
    chk("midrst_inrdy", 32'(in_ready_w[0]),  32'd1);
    rst_n = 1'b1;
    repeat (40) begin
      chk("midrst_no_late_valid", 32'(out_valid_w[0]), 32'd0);
      step();
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 55);
      out_ready = ($urandom_range(0, 99) < 70);
      rst_n     = ($urandom_range(0, 299) != 0);
      sel = $urandom_range(0, 9);
      ALU_Op = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
      OP5    = 1'($urandom);
      sel = $urandom_range(0, 4);
      funct7 = (sel == 0) ? 7'b0000000 : (sel == 1) ? 7'b0100000 :
               (sel == 4) ? 7'($urandom) : 7'b0000001;
      funct3 = 3'($urandom);
      step();
    end

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decoder_md_seq.md
Name: alu_decoder_md_seq

Overview:
Registered successor to the combinational ALU decoder. It decodes ALU_Op, OP5, funct7 and funct3 into a wider ALU control code covering all RV32I ALU operations, plus M-extension mul/div selection. It presents results through a one-entry valid/ready output stage. M-extension ops are sequenced with a latency counter, and in_ready stalls the core while they run.

Parameters:
CTRL_W, 4, width of alu_ctrl (minimum 4)
MD_EN, 1, 1 = M-extension decode/sequencing enabled; 0 = funct7 0000001 flagged illegal
MUL_LAT, 2, cycles spent in BUSY for funct3 000-011 (must be 1 or more)
DIV_LAT, 32, cycles spent in BUSY for funct3 100-111 (must be 1 or more)
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decode request
in_ready  out  1  request accepted when in_valid & in_ready
ALU_Op  in  2  00 load/store add, 01 branch sub, 10 R/I-type, 11 reserved
OP5  in  1  opcode bit 5 (1 = R-type)
funct7  in  7  instruction funct7
funct3  in  3  instruction funct3
out_valid  out  1  registered decode result valid
out_ready  in  1  consumer accepts result
alu_ctrl  out  CTRL_W  ALU control code
md_sel  out  1  result is a mul/div op
md_op  out  3  mul/div op (= funct3)
md_start  out  1  one-cycle pulse on accept of an M op
illegal  out  1  unsupported encoding (result still delivered)
busy  out  1  M-op sequencing in progress

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- alu_ctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA. Upper bits are zero-extended when CTRL_W > 4.
- ALU_Op 00 -> ADD. ALU_Op 01 -> SUB. ALU_Op 11 -> ADD with illegal=1.
- ALU_Op 10, decoded on funct3:
  - 000: SUB if OP5=1 and funct7=0100000, otherwise ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND.
  - 101: SRA if funct7[5]=1, otherwise SRL.
- ALU_Op 10 with OP5=1 and funct7=0000001, MD_EN=1 -> md_sel=1, md_op=funct3, alu_ctrl=ADD.
- illegal=1 when OP5=1 and funct7 is not one of: 0000000; 0100000 with funct3 000 or 101; 0000001 with MD_EN=1. Also illegal=1 when OP5=0, funct3=001 and funct7 is not 0000000, or OP5=0, funct3=101 and funct7 is neither 0000000 nor 0100000.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On accept of a non-M op: register the decode, go to DONE. Latency is 1 cycle.
  - On accept of an M op: register the decode, pulse md_start next cycle, load cnt with MUL_LAT-1 or DIV_LAT-1, go to BUSY.
- BUSY:
  - in_ready=0, busy=1, cnt decrements each cycle.
  - At cnt=0, go to DONE. out_valid rises MUL_LAT/DIV_LAT cycles after md_start.
- DONE:
  - out_valid=1; outputs are held stable until out_ready.
  - in_ready = out_ready (pass-through). Accept and release in the same cycle loads the new result (back-to-back, no bubble).
  - If out_ready is high and no new accept occurs, go to IDLE.
- out_valid=1 only in DONE. md_start is never asserted in DONE without a new M accept.
- in_valid while in_ready=0 is ignored; inputs need not be held.
- Reset (any state, including mid-BUSY): state=IDLE, cnt=0. out_valid, md_start, busy, md_sel and illegal all 0; alu_ctrl=0, md_op=0; in_ready=1 on the cycle after reset deasserts. An in-flight M op is discarded.
- Counter never wraps. A BUSY exit happens exactly once per M op.

Decomposition:
- Shared package alu_pkg: ALU code constants (ALU_ADD..ALU_SRA), ALU_Op constants, funct7 constants (F7_BASE=0000000, F7_ALT=0100000, F7_MD=0000001), FSM state enum.
- One sub-module, alu_ctrl_comb: purely combinational decode producing alu_ctrl, md_sel, md_op and illegal. The top holds the FSM, counter and output register.

Test Plan:
- Reset mid-BUSY (DIV accepted, rst_n=0 at cnt=10) -> next cycle state IDLE, out_valid=0, busy=0, in_ready=1; no late out_valid.
- R-type sweep, out_ready=1: OP5=1, funct7=0100000, funct3=000 -> alu_ctrl=1 one cycle after accept. funct3=101/funct7=0100000 -> 9. funct3=111/funct7=0000000 -> 2. illegal=0.
- I-type shifts: OP5=0, funct3=101, funct7=0100000 -> 9; funct7=0000000 -> 8; funct3=000 with funct7=0100000 -> ADD (0).
- MUL (funct3=000, funct7=0000001, MUL_LAT=2) -> md_start pulse, busy 2 cycles, out_valid with md_sel=1, md_op=0. DIVU (funct3=101) -> out_valid 32 cycles after md_start; in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles after a result -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> next result lands the following cycle, no bubble.
- Illegal: ALU_Op=11 -> ADD with illegal=1. OP5=1, funct7=1111111 -> illegal=1. MD_EN=0 build with funct7=0000001 -> illegal=1, md_sel=0, latency 1.
